// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_ADDR_WIDTH = 8;
   localparam int APB_DATA_WIDTH = 32;
   localparam int APB_STRB_WIDTH = 4;

endpackage

// File: rtl/apb_master.sv
// APB4 master bridge: turns a level-style local request into SETUP/ACCESS
// bus cycles and reports completion, slave error and read data.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH = APB_DATA_WIDTH,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  PCLK,
   input  logic                  PRESET_n,
   input  logic                  transfer,
   input  logic                  write_read,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] wdata_in,
   input  logic [STRB_WIDTH-1:0] strb_in,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic [STRB_WIDTH-1:0] PSTRB,
   output logic                  transfer_done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] rdata_out
);

   apb_state_e state;

   // Single registered FSM; request fields are captured only when a new
   // transfer is launched, either from IDLE or back-to-back at completion.
   // Reads drive zero strobes since PSTRB is meaningless for them.
   always_ff @(posedge PCLK) begin
      if (!PRESET_n) begin
         state         <= IDLE;
         PSEL          <= 1'b0;
         PENABLE       <= 1'b0;
         PWRITE        <= 1'b0;
         PADDR         <= '0;
         PWDATA        <= '0;
         PSTRB         <= '0;
         transfer_done <= 1'b0;
         error         <= 1'b0;
         rdata_out     <= '0;
      end else begin
         transfer_done <= 1'b0;
         error         <= 1'b0;
         case (state)
            IDLE: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               if (transfer) begin
                  PWRITE  <= write_read;
                  PADDR   <= addr_in;
                  PWDATA  <= wdata_in;
                  PSTRB   <= write_read ? strb_in : '0;
                  PSEL    <= 1'b1;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               PSEL    <= 1'b1;
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  transfer_done <= 1'b1;
                  error         <= PSLVERR;
                  if (!PWRITE) begin
                     rdata_out <= PRDATA;
                  end
                  PENABLE <= 1'b0;
                  if (transfer) begin
                     PWRITE <= write_read;
                     PADDR  <= addr_in;
                     PWDATA <= wdata_in;
                     PSTRB  <= write_read ? strb_in : '0;
                     PSEL   <= 1'b1;
                     state  <= SETUP;
                  end else begin
                     PSEL  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master with hand-computed expectations.
module tb_apb_master;

   logic        PCLK = 1'b0;
   logic        PRESET_n;
   logic        transfer;
   logic        write_read;
   logic [7:0]  addr_in;
   logic [31:0] wdata_in;
   logic [3:0]  strb_in;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PADDR;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        transfer_done;
   logic        error;
   logic [31:0] rdata_out;

   int checks = 0;
   int errors = 0;

   apb_master dut (
      .PCLK          (PCLK),
      .PRESET_n      (PRESET_n),
      .transfer      (transfer),
      .write_read    (write_read),
      .addr_in       (addr_in),
      .wdata_in      (wdata_in),
      .strb_in       (strb_in),
      .PRDATA        (PRDATA),
      .PREADY        (PREADY),
      .PSLVERR       (PSLVERR),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PWRITE        (PWRITE),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PSTRB         (PSTRB),
      .transfer_done (transfer_done),
      .error         (error),
      .rdata_out     (rdata_out)
   );

   always #5 PCLK = ~PCLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance one clock edge and settle so outputs are sampled away from it.
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      write_read = wr;
      addr_in    = a;
      wdata_in   = d;
      strb_in    = s;
   endtask

   initial begin
      PRESET_n = 1'b0;
      transfer = 1'b1;
      PREADY   = 1'b1;
      PSLVERR  = 1'b0;
      PRDATA   = 32'h0;
      applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);

      // Reset held with transfer asserted
      tick();
      checkOutput("rst_psel_1", {31'd0, PSEL}, 32'd0);
      tick();
      checkOutput("rst_psel", {31'd0, PSEL}, 32'd0);
      checkOutput("rst_penable", {31'd0, PENABLE}, 32'd0);
      checkOutput("rst_pwrite", {31'd0, PWRITE}, 32'd0);
      checkOutput("rst_paddr", {24'd0, PADDR}, 32'd0);
      checkOutput("rst_pwdata", PWDATA, 32'd0);
      checkOutput("rst_pstrb", {28'd0, PSTRB}, 32'd0);
      checkOutput("rst_done", {31'd0, transfer_done}, 32'd0);
      checkOutput("rst_error", {31'd0, error}, 32'd0);
      checkOutput("rst_rdata", rdata_out, 32'd0);

      // Zero-wait write
      PRESET_n = 1'b1;
      tick();
      checkOutput("wr_setup_psel", {31'd0, PSEL}, 32'd1);
      checkOutput("wr_setup_penable", {31'd0, PENABLE}, 32'd0);
      transfer = 1'b0;
      tick();
      checkOutput("wr_acc_penable", {31'd0, PENABLE}, 32'd1);
      checkOutput("wr_acc_psel", {31'd0, PSEL}, 32'd1);
      checkOutput("wr_acc_paddr", {24'd0, PADDR}, 32'h10);
      checkOutput("wr_acc_pwdata", PWDATA, 32'hDEADBEEF);
      checkOutput("wr_acc_pstrb", {28'd0, PSTRB}, 32'hF);
      checkOutput("wr_acc_pwrite", {31'd0, PWRITE}, 32'd1);
      checkOutput("wr_acc_done", {31'd0, transfer_done}, 32'd0);
      tick();
      checkOutput("wr_done", {31'd0, transfer_done}, 32'd1);
      checkOutput("wr_error", {31'd0, error}, 32'd0);
      checkOutput("wr_idle_psel", {31'd0, PSEL}, 32'd0);
      tick();
      checkOutput("wr_done_pulse", {31'd0, transfer_done}, 32'd0);
      checkOutput("wr_hold_paddr", {24'd0, PADDR}, 32'h10);

      // Read with three wait states
      applyStimulus(1'b0, 8'h24, 32'h55555555, 4'hF);
      transfer = 1'b1;
      PREADY   = 1'b0;
      tick();
      checkOutput("rd_setup_psel", {31'd0, PSEL}, 32'd1);
      checkOutput("rd_setup_pstrb", {28'd0, PSTRB}, 32'd0);
      checkOutput("rd_setup_pwrite", {31'd0, PWRITE}, 32'd0);
      checkOutput("rd_setup_paddr", {24'd0, PADDR}, 32'h24);
      transfer = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checkOutput($sformatf("rd_wait%0d_penable", i), {31'd0, PENABLE}, 32'd1);
         checkOutput($sformatf("rd_wait%0d_done", i), {31'd0, transfer_done}, 32'd0);
         if (i == 4) begin
            PREADY = 1'b1;
            PRDATA = 32'hCAFEF00D;
         end else begin
            PRDATA = 32'h0BAD0000 + i;
         end
      end
      tick();
      checkOutput("rd_done", {31'd0, transfer_done}, 32'd1);
      checkOutput("rd_error", {31'd0, error}, 32'd0);
      checkOutput("rd_rdata", rdata_out, 32'hCAFEF00D);
      checkOutput("rd_idle_penable", {31'd0, PENABLE}, 32'd0);
      PRDATA = 32'h11111111;

      // Write with slave error; rdata_out must not change
      applyStimulus(1'b1, 8'h08, 32'h12345678, 4'h3);
      transfer = 1'b1;
      PSLVERR  = 1'b1;
      tick();
      transfer = 1'b0;
      tick();
      checkOutput("err_acc_pstrb", {28'd0, PSTRB}, 32'h3);
      checkOutput("err_acc_error", {31'd0, error}, 32'd0);
      tick();
      checkOutput("err_done", {31'd0, transfer_done}, 32'd1);
      checkOutput("err_error", {31'd0, error}, 32'd1);
      checkOutput("err_rdata_hold", rdata_out, 32'hCAFEF00D);
      PSLVERR = 1'b0;
      tick();
      checkOutput("err_error_pulse", {31'd0, error}, 32'd0);
      checkOutput("err_hold_paddr", {24'd0, PADDR}, 32'h08);

      // Back-to-back write 0x00 then read 0x04
      applyStimulus(1'b1, 8'h00, 32'hAAAA5555, 4'hF);
      transfer = 1'b1;
      tick();
      checkOutput("b2b_setup1_paddr", {24'd0, PADDR}, 32'h00);
      applyStimulus(1'b0, 8'h04, 32'h0, 4'hF);
      tick();
      checkOutput("b2b_acc1_penable", {31'd0, PENABLE}, 32'd1);
      checkOutput("b2b_acc1_paddr", {24'd0, PADDR}, 32'h00);
      checkOutput("b2b_acc1_pwrite", {31'd0, PWRITE}, 32'd1);
      tick();
      checkOutput("b2b_setup2_psel", {31'd0, PSEL}, 32'd1);
      checkOutput("b2b_setup2_penable", {31'd0, PENABLE}, 32'd0);
      checkOutput("b2b_setup2_paddr", {24'd0, PADDR}, 32'h04);
      checkOutput("b2b_setup2_pwrite", {31'd0, PWRITE}, 32'd0);
      checkOutput("b2b_done1", {31'd0, transfer_done}, 32'd1);
      transfer = 1'b0;
      PRDATA   = 32'h0BADCAFE;
      tick();
      checkOutput("b2b_acc2_penable", {31'd0, PENABLE}, 32'd1);
      checkOutput("b2b_acc2_done", {31'd0, transfer_done}, 32'd0);
      tick();
      checkOutput("b2b_done2", {31'd0, transfer_done}, 32'd1);
      checkOutput("b2b_rdata", rdata_out, 32'h0BADCAFE);
      checkOutput("b2b_idle_psel", {31'd0, PSEL}, 32'd0);

      // Reset while stalled in ACCESS
      applyStimulus(1'b1, 8'h30, 32'h87654321, 4'hC);
      transfer = 1'b1;
      PREADY   = 1'b0;
      tick();
      transfer = 1'b0;
      tick();
      checkOutput("abort_acc_penable", {31'd0, PENABLE}, 32'd1);
      PRESET_n = 1'b0;
      tick();
      checkOutput("abort_psel", {31'd0, PSEL}, 32'd0);
      checkOutput("abort_penable", {31'd0, PENABLE}, 32'd0);
      checkOutput("abort_paddr", {24'd0, PADDR}, 32'd0);
      checkOutput("abort_pwdata", PWDATA, 32'd0);
      checkOutput("abort_done", {31'd0, transfer_done}, 32'd0);
      checkOutput("abort_rdata", rdata_out, 32'd0);
      PRESET_n = 1'b1;
      PREADY   = 1'b1;
      tick();
      checkOutput("abort_after_done", {31'd0, transfer_done}, 32'd0);
      checkOutput("abort_after_psel", {31'd0, PSEL}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB (AMBA APB4-style) bus master bridge. Converts a simple request interface (transfer, write_read, addr_in, wdata_in, strb_in) into APB SETUP/ACCESS bus cycles toward a single slave.
- Returns completion status (transfer_done, error) and read data (rdata_out) to the requester.
- Sits between a local controller and the APB slave-side fabric.

Parameters:
- ADDR_WIDTH, 8, width of addr_in/PADDR
- DATA_WIDTH, 32, width of wdata_in/PWDATA/PRDATA/rdata_out
- STRB_WIDTH, DATA_WIDTH/8 (4), byte-strobe width

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET_n  in  1  synchronous active-low reset
- transfer  in  1  request a transaction; level, sampled in IDLE and at completion
- write_read  in  1  1=write, 0=read
- addr_in  in  ADDR_WIDTH  request address
- wdata_in  in  DATA_WIDTH  write data
- strb_in  in  STRB_WIDTH  write byte strobes
- PRDATA  in  DATA_WIDTH  slave read data
- PREADY  in  1  slave ready; extends ACCESS while low
- PSLVERR  in  1  slave error; valid only when PREADY=1 in ACCESS
- PSEL  out  1  slave select
- PENABLE  out  1  access phase indicator
- PWRITE  out  1  direction
- PADDR  out  ADDR_WIDTH  bus address
- PWDATA  out  DATA_WIDTH  bus write data
- PSTRB  out  STRB_WIDTH  bus strobes
- transfer_done  out  1  one-cycle completion pulse
- error  out  1  one-cycle error flag, coincident with transfer_done
- rdata_out  out  DATA_WIDTH  captured read data

Behaviour:
- Interface: one clock (PCLK); reset PRESET_n is synchronous and active-low.
- All outputs are registered. Reset (PRESET_n=0 at an edge): state=IDLE, every output 0. Reset has priority in any state, including mid-ACCESS. No completion is reported for an aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - On an edge with transfer=1: latch write_read, addr_in, wdata_in, strb_in into PWRITE, PADDR, PWDATA, PSTRB, then go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, for exactly one cycle; unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - PREADY=0: stay in ACCESS; no limit on wait states.
  - PREADY=1 at an edge:
    - transfer_done=1 and error=PSLVERR, both for the following cycle only.
    - If PWRITE=0, rdata_out<=PRDATA. rdata_out holds until the next read completes; writes do not change it.
    - Next state: if transfer=1, latch new request fields and go to SETUP (back-to-back, PSEL stays 1, PENABLE drops). Otherwise go to IDLE.
- Reads: PSTRB is driven 0 regardless of strb_in. PWDATA is driven with latched wdata_in (don't-care to slave).
- Minimum transfer: zero-wait transfer = 2 cycles of PSEL, with transfer_done the cycle after PREADY is sampled.
- After return to IDLE, PADDR, PWRITE, PWDATA and PSTRB hold their last values (not cleared).
- Request fields are sampled only when leaving IDLE or at completion. Changes at other times are ignored.
- PSLVERR and PRDATA are ignored outside the ACCESS+PREADY edge.

Decomposition:
- Package apb_master_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS}
  - localparams APB_ADDR_WIDTH=8, APB_DATA_WIDTH=32, APB_STRB_WIDTH=4
- Single flat module; no sub-module needed. FSM next-state logic and output registers live in one file.

Test Plan:
- Reset: hold PRESET_n=0 for 2 cycles with transfer=1 -> all outputs 0, PSEL never asserts. Release -> SETUP begins one cycle after the first edge with PRESET_n=1 and transfer=1.
- Zero-wait write: addr_in=0x10, wdata_in=0xDEADBEEF, strb_in=0xF, write_read=1, PREADY=1 -> PSEL=1/PENABLE=0 one cycle, then PENABLE=1 one cycle with PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=0xF, PWRITE=1. Next cycle transfer_done=1, error=0.
- Read with 3 wait states: addr_in=0x24, write_read=0, PREADY low 3 ACCESS cycles then high with PRDATA=0xCAFEF00D -> PENABLE high 4 cycles, PSTRB=0, rdata_out=0xCAFEF00D with transfer_done pulse. rdata_out unchanged by a subsequent write.
- Slave error: write to 0x08 with PSLVERR=1 coincident with PREADY=1 -> error=1 and transfer_done=1 for one cycle. Next clean transfer reports error=0.
- Back-to-back: transfer held 1 with write 0x00 then read 0x04 -> PSEL stays 1 across boundary, PENABLE 1→0→1, PADDR 0x00→0x04 at the new SETUP.
- Reset mid-ACCESS: PRESET_n=0 while PREADY=0 in ACCESS -> next cycle all outputs 0, no transfer_done pulse.
